// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud divisor helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(int clk_hz, int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_axis_tx_if.sv
// Byte-wide AXI-stream link feeding the UART transmitter.
interface uart_axis_tx_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done on the last count.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] bit_cnt_clk_reg;

    assign bit_done = enable && (bit_cnt_clk_reg == LAST_CNT);

    // Wrapping at bit_done means every bit boundary (and thus every state change) restarts at 0.
    always_ff @(posedge clk) begin
        if (clear) begin
            bit_cnt_clk_reg <= '0;
        end else if (enable) begin
            bit_cnt_clk_reg <= bit_done ? '0 : bit_cnt_clk_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_axis_tx.sv
// AXI-stream to UART serializer: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_axis_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic           s00_axis_aclk,
    input  logic           s00_axis_areset,
    uart_axis_tx_if.slave  s00_axis,
    output logic           tx,
    output logic           busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_axis_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_axis_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_axis_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t  state_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx_reg;
    logic       tx_reg;
    logic       busy_reg;
    logic       bit_done;
    logic       last_stop;
    logic       accept;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (s00_axis_aclk),
        .clear    (s00_axis_areset || (state_reg == ST_IDLE)),
        .enable   (state_reg != ST_IDLE),
        .bit_done (bit_done)
    );

    // The final cycle of the final stop bit doubles as an accept slot for gapless frames.
    assign last_stop      = (state_reg == ST_STOP) && bit_done &&
                            (bit_idx_reg == 3'(STOP_BITS - 1));
    assign s00_axis.tready = !s00_axis_areset && ((state_reg == ST_IDLE) || last_stop);
    assign accept         = s00_axis.tvalid && s00_axis.tready;

    assign tx   = tx_reg;
    assign busy = busy_reg;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axis.tlast};

`ifdef UART_TX_PARITY_EN
    genvar gi;
    logic [7:0] data_mask;
    logic       parity_reg;
    for (gi = 0; gi < 8; gi++) begin : g_mask
        assign data_mask[gi] = (gi < DATA_BITS);
    end
`endif

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else if (accept) begin
            state_reg   <= ST_START;
            shift_reg   <= s00_axis.tdata;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= ^(s00_axis.tdata & data_mask);
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
                ST_START: begin
                    if (bit_done) begin
                        state_reg   <= ST_DATA;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
                            bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
                            state_reg   <= ST_PARITY;
                            tx_reg      <= parity_reg;
`else
                            state_reg   <= ST_STOP;
                            tx_reg      <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state_reg <= ST_STOP;
                        tx_reg    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (last_stop) begin
                        state_reg   <= ST_IDLE;
                        bit_idx_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else if (bit_done) begin
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_axis_tx.sv
// Directed bench for uart_axis_tx at 4 clocks per bit; one DUT with 1 stop bit, one with 2.
module tb_uart_axis_tx;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic srst;
    logic tx1, busy1, tx2, busy2;
    int   nvec = 0;
    int   nerr = 0;

    uart_axis_tx_if if1 ();
    uart_axis_tx_if if2 ();

    uart_axis_tx #(.CLK_FREQ_HZ(16), .BAUD_RATE(4), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .s00_axis_aclk(clk), .s00_axis_areset(srst), .s00_axis(if1), .tx(tx1), .busy(busy1));
    uart_axis_tx #(.CLK_FREQ_HZ(16), .BAUD_RATE(4), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .s00_axis_aclk(clk), .s00_axis_areset(srst), .s00_axis(if2), .tx(tx2), .busy(busy2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            if1.tvalid = v;
            if1.tdata  = d;
        end else begin
            if2.tvalid = v;
            if2.tdata  = d;
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (P == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    // Entered one cycle after the handshake edge; leaves one cycle after the frame's last edge.
    task automatic frame_check(input int sel, input logic [7:0] d, input int stops,
                               input logic next_valid, input logic [7:0] next_data);
        int frame;
        frame = (1 + 8 + P + stops) * CPB;
        for (int k = 1; k <= frame; k++) begin
            chk($sformatf("tx d=%02h c%0d", d, k), sel ? tx2 : tx1, exp_bit(d, (k - 1) / CPB));
            chk($sformatf("busy d=%02h c%0d", d, k), sel ? busy2 : busy1, 1'b1);
            chk($sformatf("tready d=%02h c%0d", d, k), sel ? if2.tready : if1.tready, k == frame);
            if (k == 5) drive(sel, 1'b1, ~d);
            if (k == frame) drive(sel, next_valid, next_data);
            tick();
        end
    endtask

    task automatic idle_check(input int sel, input string tag);
        chk({tag, " idle tx"}, sel ? tx2 : tx1, 1'b1);
        chk({tag, " idle busy"}, sel ? busy2 : busy1, 1'b0);
        chk({tag, " idle tready"}, sel ? if2.tready : if1.tready, 1'b1);
    endtask

    initial begin
        srst = 1'b1;
        if1.tvalid = 1'b0; if1.tdata = 8'h00; if1.tlast = 1'b0;
        if2.tvalid = 1'b0; if2.tdata = 8'h00; if2.tlast = 1'b0;
        tick(); tick();
        chk("reset tx", tx1, 1'b1);
        chk("reset busy", busy1, 1'b0);
        chk("reset tready", if1.tready, 1'b0);
        chk("reset tready2", if2.tready, 1'b0);
        srst = 1'b0;
        tick();
        idle_check(0, "post-reset");

        // Single byte 0xA5, tdata/tvalid disturbed mid-frame
        drive(0, 1'b1, 8'hA5); if1.tlast = 1'b1;
        tick();
        drive(0, 1'b0, 8'h00);
        frame_check(0, 8'hA5, 1, 1'b0, 8'h00);
        idle_check(0, "after A5");

        // Back-to-back 0x00 then 0xFF with tvalid held high
        drive(0, 1'b1, 8'h00);
        tick();
        frame_check(0, 8'h00, 1, 1'b1, 8'hFF);
        frame_check(0, 8'hFF, 1, 1'b0, 8'h00);
        idle_check(0, "after b2b");

        // Reset during data bit 3
        drive(0, 1'b1, 8'h00);
        tick();
        drive(0, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) tick();
        chk("mid-frame tx", tx1, 1'b0);
        chk("mid-frame busy", busy1, 1'b1);
        srst = 1'b1;
        tick();
        chk("abort tx", tx1, 1'b1);
        chk("abort busy", busy1, 1'b0);
        chk("abort tready", if1.tready, 1'b0);
        srst = 1'b0;
        tick();
        idle_check(0, "after abort");
        drive(0, 1'b1, 8'h3C);
        tick();
        drive(0, 1'b0, 8'h00);
        frame_check(0, 8'h3C, 1, 1'b0, 8'h00);
        idle_check(0, "after 3C");

        // Two stop bits
        idle_check(1, "dut2 start");
        drive(1, 1'b1, 8'h55);
        tick();
        drive(1, 1'b0, 8'h00);
        frame_check(1, 8'h55, 2, 1'b0, 8'h00);
        idle_check(1, "after 55");

`ifdef UART_TX_PARITY_EN
        // Odd and even popcount bytes
        drive(0, 1'b1, 8'h07);
        tick();
        frame_check(0, 8'h07, 1, 1'b1, 8'h03);
        frame_check(0, 8'h03, 1, 1'b0, 8'h00);
        idle_check(0, "after parity");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
